// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32 subset core.
package core_pkg;
    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF/ID pipeline register in front of an asynchronous ROM.
// Handles stall, redirect, a one-cycle boot state and a sticky fault on illegal fetch addresses.
module instruction_fetch
    import core_pkg::*;
#(
    parameter int                WIDTH    = 32,
    parameter int                DEPTH    = 2048,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clock,
    input  logic             nreset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] rom_address,
    input  logic [WIDTH-1:0] rom_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             fault,
    output logic [WIDTH-1:0] fetch_count
);
    localparam logic [WIDTH-1:0] LAST_PC = WIDTH'(4 * DEPTH - 4);

    function automatic logic pc_legal(input logic [WIDTH-1:0] a);
        return (a[1:0] == 2'b00) && (a <= LAST_PC);
    endfunction

    fetch_state_t     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] ipc_q, ipc_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        case (state_q)
            BOOT: state_d = pc_legal(RESET_PC) ? RUN : FAULT;
            RUN: begin
                if (redirect_valid) begin
                    // The word fetched this cycle is on the wrong path, so it is squashed.
                    valid_d = 1'b0;
                    if (pc_legal(redirect_pc)) pc_d = redirect_pc;
                    else state_d = FAULT;
                end else if (!stall) begin
                    instr_d = rom_rdata;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (pc_q == LAST_PC) state_d = FAULT;
                    else pc_d = pc_q + WIDTH'(4);
                end
            end
            FAULT:   valid_d = 1'b0;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            instr_q <= WIDTH'(NOP_INSTR);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_address = pc_q;
    assign if_valid    = valid_q;
    assign if_pc       = ipc_q;
    assign if_instr    = instr_q;
    assign fault       = (state_q == FAULT);
    assign fetch_count = cnt_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed and randomized checks of instruction_fetch against a cycle model.
module tb_instruction_fetch;
    localparam int          DEPTH = 2048;
    localparam logic [31:0] LAST  = 32'(4 * DEPTH - 4);

    logic        clock = 1'b0;
    logic        nreset, stall, redirect_valid;
    logic [31:0] redirect_pc, rom_address, rom_rdata, if_pc, if_instr, fetch_count;
    logic        if_valid, fault;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_pc, m_ipc, m_instr, m_cnt;
    logic        m_valid, m_fault, m_boot;

    instruction_fetch #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clock(clock), .nreset(nreset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .rom_address(rom_address), .rom_rdata(rom_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .fault(fault), .fetch_count(fetch_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign rom_rdata = rom_word(rom_address);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (!nreset) begin
            m_pc = 0; m_valid = 0; m_ipc = 0; m_instr = 32'h13; m_fault = 0; m_cnt = 0; m_boot = 1;
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_fault) begin
            m_valid = 0;
        end else if (redirect_valid) begin
            m_valid = 0;
            if (redirect_pc % 4 != 0 || redirect_pc > LAST) m_fault = 1;
            else m_pc = redirect_pc;
        end else if (!stall) begin
            m_instr = rom_word(m_pc);
            m_ipc   = m_pc;
            m_valid = 1;
            m_cnt   = m_cnt + 1;
            if (m_pc == LAST) m_fault = 1;
            else m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all();
        check("rom_address", rom_address, m_pc);
        check("if_valid", 32'(if_valid), 32'(m_valid));
        check("if_pc", if_pc, m_ipc);
        check("if_instr", if_instr, m_instr);
        check("fault", 32'(fault), 32'(m_fault));
        check("fetch_count", fetch_count, m_cnt);
    endtask

    task automatic drive(input logic n, input logic s, input logic rv, input logic [31:0] rpc);
        nreset = n; stall = s; redirect_valid = rv; redirect_pc = rpc;
    endtask

    task automatic step();
        @(posedge clock);
        model_update();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0);
    endtask

    initial begin
        m_boot = 1; m_pc = 0; m_valid = 0; m_ipc = 0; m_instr = 32'h13; m_fault = 0; m_cnt = 0;
        drive(0, 0, 0, 0);
        step();
        check("reset_instr_nop", if_instr, 32'h0000_0013);
        drive(1, 0, 0, 0);
        step();
        check("boot_no_valid", 32'(if_valid), 32'h0);
        repeat (3) step();
        check("free_if_pc", if_pc, 32'h8);
        check("free_if_instr", if_instr, 32'h1000_0002);
        check("free_count", fetch_count, 32'd3);
        drive(1, 1, 0, 0);
        repeat (2) step();
        check("stall_count", fetch_count, 32'd3);
        check("stall_if_pc", if_pc, 32'h8);
        drive(1, 1, 1, 32'h40);
        step();
        check("redir_squash", 32'(if_valid), 32'h0);
        drive(1, 0, 0, 0);
        step();
        check("redir_if_pc", if_pc, 32'h40);
        check("redir_if_instr", if_instr, 32'h1000_0010);

        drive(1, 0, 1, 32'h42);
        step();
        check("misalign_fault", 32'(fault), 32'h1);
        check("misalign_addr_held", rom_address, 32'h44);
        drive(1, 0, 0, 0);
        repeat (3) step();
        check("fault_sticky_valid", 32'(if_valid), 32'h0);
        do_reset();
        check("reset_clears_fault", 32'(fault), 32'h0);
        check("reset_pc", rom_address, 32'h0);

        step();
        drive(1, 0, 1, LAST);
        step();
        drive(1, 0, 0, 0);
        step();
        check("last_delivered_pc", if_pc, LAST);
        check("last_delivered_valid", 32'(if_valid), 32'h1);
        check("last_fault", 32'(fault), 32'h1);
        step();
        check("last_no_wrap", rom_address, LAST);
        do_reset();

        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            int r;
            r = int'($urandom_range(0, 99));
            case ($urandom_range(0, 7))
                0: t = LAST - 32'(4 * $urandom_range(0, 3));
                1: t = 32'($urandom);
                2: t = {$urandom_range(0, DEPTH - 1), 2'b00} | 32'($urandom_range(1, 3));
                default: t = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
            endcase
            drive(r >= 2, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 12, t);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
